// File: rtl/wb_serial_master_pkg.sv
// ----------------------------------------------------------------------------
// wb_serial_master_pkg
// Shared constants for the byte-stream-to-WISHBONE debug initiator:
//   - command opcodes received from the host (CMD_WR, CMD_RD)
//   - response codes returned to the host (RSP_OK, RSP_TO)
//   - parser/bus FSM state encoding (localparams plus the matching enum)
// ----------------------------------------------------------------------------
package wb_serial_master_pkg;

    localparam logic [7:0] CMD_WR = 8'h57;  // 'W' ADDR DATA
    localparam logic [7:0] CMD_RD = 8'h52;  // 'R' ADDR
    localparam logic [7:0] RSP_OK = 8'h4B;  // 'K' write acknowledged
    localparam logic [7:0] RSP_TO = 8'hEE;  // bus timeout, either command

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GET_ADR = 3'd1;
    localparam logic [2:0] ST_GET_DAT = 3'd2;
    localparam logic [2:0] ST_BUS     = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_GET_ADR = ST_GET_ADR,
        S_GET_DAT = ST_GET_DAT,
        S_BUS     = ST_BUS,
        S_RESP    = ST_RESP
    } state_t;

endpackage

// File: rtl/wb_serial_master_if.sv
// ----------------------------------------------------------------------------
// wb_serial_master_if
// Groups the three links of the debug initiator:
//   rx_*  : byte stream from the UART receiver   (valid/ready)
//   tx_*  : response byte to the UART transmitter (valid/ready)
//   wb_*  : 8-bit WISHBONE classic peripheral bus (stb doubles as cyc)
// Modports:
//   master : the initiator (wb_serial_master)
//   slave  : everything around it (UART byte ports, bus slave)
// ----------------------------------------------------------------------------
interface wb_serial_master_if #(
    parameter int ADR_W = 8
);
    logic [7:0]       rx_dat_i;
    logic             rx_valid_i;
    logic             rx_ready_o;
    logic [7:0]       tx_dat_o;
    logic             tx_valid_o;
    logic             tx_ready_i;
    logic [ADR_W-1:0] wb_adr_o;
    logic [7:0]       wb_dat_o;
    logic [7:0]       wb_dat_i;
    logic             wb_we_o;
    logic             wb_stb_o;
    logic             wb_ack_i;

    modport master (
        input  rx_dat_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i,
        output rx_ready_o, tx_dat_o, tx_valid_o, wb_adr_o, wb_dat_o,
               wb_we_o, wb_stb_o
    );

    modport slave (
        output rx_dat_i, rx_valid_i, tx_ready_i, wb_dat_i, wb_ack_i,
        input  rx_ready_o, tx_dat_o, tx_valid_o, wb_adr_o, wb_dat_o,
               wb_we_o, wb_stb_o
    );
endinterface

// File: rtl/wb_serial_master.sv
// ----------------------------------------------------------------------------
// wb_serial_master
// Parses 'W' ADDR DATA / 'R' ADDR frames from a UART byte stream, runs one
// WISHBONE classic cycle per frame and returns one response byte:
// 0x4B after a write, the read data after a read, 0xEE on bus timeout.
// A frame left incomplete for BYTE_TIMEOUT cycles is dropped silently.
// Ports:
//   wb_clk_i  clock, rising edge
//   wb_rst_i  synchronous active-high reset
//   bus_if    rx byte stream, tx response byte, WISHBONE master signals
//   busy_o    high in every state except IDLE
// ----------------------------------------------------------------------------
module wb_serial_master
    import wb_serial_master_pkg::*;
#(
    parameter int ADR_W        = 8,      // <= 8, address byte truncated
    parameter int BUS_TIMEOUT  = 255,    // >= 1, stb cycles before abort
    parameter int BYTE_TIMEOUT = 65535   // 0 disables the frame timeout
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_serial_master_if.master   bus_if,
    output logic                 busy_o
);

    // Timeouts fire on the last cycle of the allowed window, so stb stays
    // high for exactly BUS_TIMEOUT cycles and GET_* for BYTE_TIMEOUT cycles.
    localparam logic [7:0]  BUS_LIMIT  = 8'(BUS_TIMEOUT - 1);
    localparam logic [15:0] BYTE_LIMIT = (BYTE_TIMEOUT == 0) ? 16'hFFFF
                                                             : 16'(BYTE_TIMEOUT - 1);

    state_t           state_q,    state_d;
    logic [7:0]       bus_cnt_q,  bus_cnt_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [ADR_W-1:0] adr_q,      adr_d;
    logic [7:0]       dat_q,      dat_d;
    logic             we_q,       we_d;
    logic [7:0]       tx_dat_q,   tx_dat_d;

    logic rx_ready;
    logic rx_fire;
    logic byte_to;

    assign rx_ready = (state_q == S_IDLE) || (state_q == S_GET_ADR) ||
                      (state_q == S_GET_DAT);
    assign rx_fire  = rx_ready && bus_if.rx_valid_i;
    assign byte_to  = (BYTE_TIMEOUT != 0) && (byte_cnt_q == BYTE_LIMIT);

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        we_d     = we_q;
        tx_dat_d = tx_dat_q;

        case (state_q)
            S_IDLE: begin
                // Unknown bytes are consumed and dropped; that is how the
                // parser resynchronises on garbage.
                if (rx_fire && bus_if.rx_dat_i == CMD_WR) begin
                    we_d    = 1'b1;
                    state_d = S_GET_ADR;
                end else if (rx_fire && bus_if.rx_dat_i == CMD_RD) begin
                    we_d    = 1'b0;
                    state_d = S_GET_ADR;
                end
            end
            S_GET_ADR: begin
                if (rx_fire) begin
                    adr_d   = bus_if.rx_dat_i[ADR_W-1:0];
                    state_d = we_q ? S_GET_DAT : S_BUS;
                end else if (byte_to) begin
                    state_d = S_IDLE;
                end
            end
            S_GET_DAT: begin
                if (rx_fire) begin
                    dat_d   = bus_if.rx_dat_i;
                    state_d = S_BUS;
                end else if (byte_to) begin
                    state_d = S_IDLE;
                end
            end
            S_BUS: begin
                if (bus_if.wb_ack_i) begin
                    tx_dat_d = we_q ? RSP_OK : bus_if.wb_dat_i;
                    state_d  = S_RESP;
                end else if (bus_cnt_q == BUS_LIMIT) begin
                    tx_dat_d = RSP_TO;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (bus_if.tx_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Both counters restart on any state change and saturate otherwise.
        if (state_d != state_q) begin
            bus_cnt_d  = 8'd0;
            byte_cnt_d = 16'd0;
        end else begin
            bus_cnt_d  = (bus_cnt_q  == 8'hFF)    ? bus_cnt_q  : bus_cnt_q  + 8'd1;
            byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            bus_cnt_q  <= 8'd0;
            byte_cnt_q <= 16'd0;
            adr_q      <= '0;
            dat_q      <= 8'd0;
            we_q       <= 1'b0;
            tx_dat_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            bus_cnt_q  <= bus_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            tx_dat_q   <= tx_dat_d;
        end
    end

    // stb and tx_valid decode straight from the state register, so a reset
    // during BUS drops stb at that same edge and abandons the cycle.
    assign bus_if.rx_ready_o = rx_ready;
    assign bus_if.wb_stb_o   = (state_q == S_BUS);
    assign bus_if.tx_valid_o = (state_q == S_RESP);
    assign bus_if.tx_dat_o   = tx_dat_q;
    assign bus_if.wb_adr_o   = adr_q;
    assign bus_if.wb_dat_o   = dat_q;
    assign bus_if.wb_we_o    = we_q;
    assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_serial_master.sv
// ----------------------------------------------------------------------------
// tb_wb_serial_master
// Directed bench for wb_serial_master with BUS_TIMEOUT=4, BYTE_TIMEOUT=8.
// Inputs change and outputs are sampled on the falling clock edge. A small
// bus slave acks after ack_delay extra stb cycles (-1 = never) and counts
// stb pulses and stb-high cycles.
// ----------------------------------------------------------------------------
module tb_wb_serial_master;
    import wb_serial_master_pkg::*;

    localparam int BUS_TO  = 4;
    localparam int BYTE_TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int total = 0;
    int bad   = 0;

    int         ack_delay  = 0;
    logic [7:0] rd_data    = 8'h00;
    int         stb_cycles = 0;
    int         stb_pulses = 0;
    int         k          = 0;
    logic       prev_stb   = 1'b0;
    logic       ack        = 1'b0;

    wb_serial_master_if #(.ADR_W(8)) bus();

    assign bus.wb_dat_i = rd_data;
    assign bus.wb_ack_i = ack;

    always #5 clk = ~clk;

    wb_serial_master #(
        .ADR_W       (8),
        .BUS_TIMEOUT (BUS_TO),
        .BYTE_TIMEOUT(BYTE_TO)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .bus_if  (bus.master),
        .busy_o  (busy)
    );

    // Bus slave: ack is raised on the falling edge of stb cycle ack_delay+1,
    // so ack_delay=0 behaves like a combinational zero-wait slave.
    always @(negedge clk) begin
        prev_stb <= bus.wb_stb_o;
        if (bus.wb_stb_o) begin
            stb_cycles <= stb_cycles + 1;
            if (!prev_stb) begin
                stb_pulses <= stb_pulses + 1;
                k          <= 1;
                ack        <= (ack_delay == 0);
            end else begin
                k   <= k + 1;
                ack <= (ack_delay > 0) && (k == ack_delay);
            end
        end else begin
            k   <= 0;
            ack <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Presents one byte, waits (bounded) for acceptance, returns on the
    // falling edge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_dat_i   = b;
        bus.rx_valid_i = 1'b1;
        while (!bus.rx_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.rx_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL send_byte %02h: rx_ready_o=%b after %0d cycles, required 1",
                     b, bus.rx_ready_o, n);
        end
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    // Waits (bounded) for tx_valid_o; returns on the falling edge where it is seen.
    task automatic wait_tx(output logic [7:0] b, output bit seen);
        int n = 0;
        while (!bus.tx_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        seen = (bus.tx_valid_o === 1'b1);
        b    = bus.tx_dat_o;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (bus.wb_stb_o !== 1'b0 || bus.tx_valid_o !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: stb=%b tx_valid=%b busy=%b, required 0 0 0",
                     bus.wb_stb_o, bus.tx_valid_o, busy);
        end
        total++;
        if (bus.wb_adr_o !== 8'h00 || bus.wb_dat_o !== 8'h00 || bus.wb_we_o !== 1'b0 ||
            bus.tx_dat_o !== 8'h00) begin
            bad++;
            $display("FAIL reset_data: adr=%02h dat=%02h we=%b tx_dat=%02h, required 00 00 0 00",
                     bus.wb_adr_o, bus.wb_dat_o, bus.wb_we_o, bus.tx_dat_o);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rx_ready_o !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: rx_ready=%b busy=%b, required 1 0", bus.rx_ready_o, busy);
        end
    endtask

    task automatic test_write();
        int p0, c0;
        logic [7:0] r;
        bit seen;
        ack_delay = 2;
        p0 = stb_pulses;
        c0 = stb_cycles;
        send_byte(CMD_WR);
        send_byte(8'h01);
        send_byte(8'hA5);
        total++;
        if (bus.wb_stb_o !== 1'b1 || bus.wb_we_o !== 1'b1 || bus.wb_adr_o !== 8'h01 ||
            bus.wb_dat_o !== 8'hA5) begin
            bad++;
            $display("FAIL write_bus: stb=%b we=%b adr=%02h dat=%02h, required 1 1 01 A5",
                     bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o);
        end
        wait_tx(r, seen);
        total++;
        if (!seen || r !== RSP_OK) begin
            bad++;
            $display("FAIL write_resp: seen=%0d data=%02h, required 1 4b", seen, r);
        end
        @(negedge clk);
        total++;
        if (stb_pulses - p0 != 1 || stb_cycles - c0 != 3) begin
            bad++;
            $display("FAIL write_stb: pulses=%0d cycles=%0d, required 1 3",
                     stb_pulses - p0, stb_cycles - c0);
        end
        total++;
        if (bus.tx_valid_o !== 1'b0 || busy !== 1'b0 || bus.rx_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL write_idle: tx_valid=%b busy=%b rx_ready=%b, required 0 0 1",
                     bus.tx_valid_o, busy, bus.rx_ready_o);
        end
    endtask

    task automatic test_read();
        int p0, c0;
        logic [7:0] r;
        bit seen;
        ack_delay = 0;
        rd_data   = 8'h3C;
        p0 = stb_pulses;
        c0 = stb_cycles;
        send_byte(CMD_RD);
        send_byte(8'h00);
        total++;
        if (bus.wb_stb_o !== 1'b1 || bus.wb_we_o !== 1'b0 || bus.wb_adr_o !== 8'h00) begin
            bad++;
            $display("FAIL read_bus: stb=%b we=%b adr=%02h, required 1 0 00",
                     bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o);
        end
        wait_tx(r, seen);
        total++;
        if (!seen || r !== 8'h3C) begin
            bad++;
            $display("FAIL read_resp: seen=%0d data=%02h, required 1 3c", seen, r);
        end
        @(negedge clk);
        total++;
        if (stb_pulses - p0 != 1 || stb_cycles - c0 != 1) begin
            bad++;
            $display("FAIL read_stb: pulses=%0d cycles=%0d, required 1 1",
                     stb_pulses - p0, stb_cycles - c0);
        end
    endtask

    task automatic test_timeout();
        int c0;
        logic [7:0] r;
        bit seen;
        ack_delay = -1;
        c0 = stb_cycles;
        send_byte(CMD_RD);
        send_byte(8'h10);
        wait_tx(r, seen);
        total++;
        if (!seen || r !== RSP_TO) begin
            bad++;
            $display("FAIL timeout_resp: seen=%0d data=%02h, required 1 ee", seen, r);
        end
        total++;
        if (stb_cycles - c0 != BUS_TO) begin
            bad++;
            $display("FAIL timeout_stb: cycles=%0d, required %0d", stb_cycles - c0, BUS_TO);
        end
        // The link must recover for the next command.
        ack_delay = 0;
        rd_data   = 8'h5A;
        send_byte(CMD_RD);
        send_byte(8'h11);
        wait_tx(r, seen);
        total++;
        if (!seen || r !== 8'h5A || bus.wb_adr_o !== 8'h11) begin
            bad++;
            $display("FAIL timeout_recover: seen=%0d data=%02h adr=%02h, required 1 5a 11",
                     seen, r, bus.wb_adr_o);
        end
        @(negedge clk);
    endtask

    task automatic test_resync();
        int p0;
        logic [7:0] r;
        bit seen;
        ack_delay = 0;
        rd_data   = 8'h77;
        p0 = stb_pulses;
        send_byte(CMD_RD);
        repeat (BYTE_TO - 1) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL resync_hold: busy=%b after %0d idle cycles, required 1", busy, BYTE_TO - 1);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || stb_pulses != p0) begin
            bad++;
            $display("FAIL resync_drop: busy=%b pulses=%0d, required 0 0", busy, stb_pulses - p0);
        end
        send_byte(CMD_RD);
        send_byte(8'h20);
        wait_tx(r, seen);
        total++;
        if (!seen || r !== 8'h77 || bus.wb_adr_o !== 8'h20 || stb_pulses - p0 != 1) begin
            bad++;
            $display("FAIL resync_read: seen=%0d data=%02h adr=%02h pulses=%0d, required 1 77 20 1",
                     seen, r, bus.wb_adr_o, stb_pulses - p0);
        end
        @(negedge clk);
    endtask

    task automatic test_garbage();
        int p0;
        logic [7:0] r;
        bit seen;
        ack_delay = 1;
        p0 = stb_pulses;
        send_byte(8'hFF);
        send_byte(8'h00);
        send_byte(8'h41);
        total++;
        if (busy !== 1'b0 || bus.wb_we_o !== 1'b0 || stb_pulses != p0) begin
            bad++;
            $display("FAIL garbage_drop: busy=%b we=%b pulses=%0d, required 0 0 0",
                     busy, bus.wb_we_o, stb_pulses - p0);
        end
        send_byte(CMD_WR);
        send_byte(8'h02);
        send_byte(8'h11);
        total++;
        if (bus.wb_we_o !== 1'b1 || bus.wb_adr_o !== 8'h02 || bus.wb_dat_o !== 8'h11) begin
            bad++;
            $display("FAIL garbage_write: we=%b adr=%02h dat=%02h, required 1 02 11",
                     bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o);
        end
        wait_tx(r, seen);
        total++;
        if (!seen || r !== RSP_OK || stb_pulses - p0 != 1) begin
            bad++;
            $display("FAIL garbage_resp: seen=%0d data=%02h pulses=%0d, required 1 4b 1",
                     seen, r, stb_pulses - p0);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [7:0] r;
        bit seen;
        int errs = 0;
        ack_delay = 0;
        rd_data   = 8'hC3;
        bus.tx_ready_i = 1'b0;
        send_byte(CMD_RD);
        send_byte(8'h30);
        wait_tx(r, seen);
        total++;
        if (!seen || r !== 8'hC3) begin
            bad++;
            $display("FAIL bp_resp: seen=%0d data=%02h, required 1 c3", seen, r);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.tx_valid_o !== 1'b1 || bus.tx_dat_o !== 8'hC3 || bus.rx_ready_o !== 1'b0)
                errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d of 10 cycles unstable (tx_valid=%b tx_dat=%02h rx_ready=%b), required 0",
                     errs, bus.tx_valid_o, bus.tx_dat_o, bus.rx_ready_o);
        end
        bus.tx_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus.tx_valid_o !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: tx_valid=%b busy=%b, required 0 0", bus.tx_valid_o, busy);
        end
    endtask

    task automatic test_reset_in_bus();
        logic [7:0] r;
        bit seen;
        int errs = 0;
        ack_delay = -1;
        send_byte(CMD_WR);
        send_byte(8'h40);
        send_byte(8'h99);
        total++;
        if (bus.wb_stb_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_bus_pre: stb=%b, required 1", bus.wb_stb_o);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.wb_stb_o !== 1'b0 || busy !== 1'b0 || bus.wb_adr_o !== 8'h00) begin
            bad++;
            $display("FAIL rst_bus_drop: stb=%b busy=%b adr=%02h, required 0 0 00",
                     bus.wb_stb_o, busy, bus.wb_adr_o);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.tx_valid_o !== 1'b0 || bus.wb_stb_o !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL rst_bus_quiet: %0d cycles with activity, required 0", errs);
        end
        ack_delay = 0;
        rd_data   = 8'h12;
        send_byte(CMD_RD);
        send_byte(8'h01);
        wait_tx(r, seen);
        total++;
        if (!seen || r !== 8'h12) begin
            bad++;
            $display("FAIL rst_bus_after: seen=%0d data=%02h, required 1 12", seen, r);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.rx_dat_i   = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.tx_ready_i = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_resync();
        test_garbage();
        test_backpressure();
        test_reset_in_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_serial_master.md
# wb_serial_master

Byte-stream-to-WISHBONE initiator for the Lattuino SoC, giving the host PC a debug path into the peripheral bus without the AVR core. It parses a three-byte command protocol arriving from a UART receiver's byte interface. It runs single WISHBONE classic read or write cycles on the 8-bit peripheral bus, the same bus the AVR drives toward UART_C, and returns one response byte per command to a UART transmitter byte interface. It includes a bus timeout, so a missing slave cannot hang the link, and an inter-byte timeout, so a truncated frame cannot desynchronise the parser.

## Interface
- ADR_W, 8, WISHBONE address width (max 8; the address byte is truncated to ADR_W LSBs)
- BUS_TIMEOUT, 255, cycles to wait for wb_ack_i before aborting (>=1)
- BYTE_TIMEOUT, 65535, idle cycles between frame bytes before the parser drops back to IDLE (0 = disabled)
- wb_clk_i  in  1  clock; all logic is on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- rx_dat_i  in  8  received byte
- rx_valid_i  in  1  rx_dat_i is valid
- rx_ready_o  out  1  byte is accepted this cycle when rx_valid_i and rx_ready_o are both high
- tx_dat_o  out  8  response byte
- tx_valid_o  out  1  response pending; held until accepted
- tx_ready_i  in  1  transmitter takes the byte when tx_valid_o and tx_ready_i are both high
- wb_adr_o  out  ADR_W  bus address
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe (also serves as cyc)
- wb_ack_i  in  1  slave acknowledge
- busy_o  out  1  high in every state except IDLE

## Operation
- Frame formats:
  - Write: 0x57 ('W'), ADDR, DATA. Response 0x4B ('K').
  - Read: 0x52 ('R'), ADDR. Response is the read data byte.
  - Bus timeout: response 0xEE, for either command. On a read this is indistinguishable from data 0xEE; the host disambiguates by re-reading.
- FSM states: IDLE, GET_ADR, GET_DAT, BUS, RESP.
- IDLE: on an accepted byte 0x57, latch we=1 and go to GET_ADR. On 0x52, latch we=0 and go to GET_ADR. Any other byte is consumed and discarded; stay in IDLE.
- GET_ADR: on an accepted byte, latch the address. Go to GET_DAT if we=1, otherwise go to BUS.
- GET_DAT: on an accepted byte, latch the data and go to BUS.
- BUS: assert wb_stb_o.
  - If wb_ack_i is high: capture wb_dat_i (read) or load 0x4B (write) into tx_dat_o, drop wb_stb_o, go to RESP.
  - If the timeout counter reaches BUS_TIMEOUT with no ack: load 0xEE, drop wb_stb_o, go to RESP.
- RESP: hold tx_valid_o high with tx_dat_o stable. On tx_ready_i, go to IDLE.
- rx_ready_o is high only in IDLE, GET_ADR and GET_DAT. Bytes are never accepted during BUS or RESP; they back-pressure at the receiver.
- Inter-byte timeout (BYTE_TIMEOUT != 0): in GET_ADR or GET_DAT, if BYTE_TIMEOUT consecutive cycles pass with no accepted byte, return to IDLE silently with no bus cycle and no response.
- Counters: the bus counter is 8 bits wide and the byte counter is 16 bits wide. Both saturate and clear on every state entry.
- wb_adr_o, wb_dat_o and wb_we_o are registered, and change only on byte acceptance.
- Reset values: all outputs 0, state IDLE, both counters 0. A reset in BUS drops wb_stb_o at that edge; the half-completed cycle is abandoned and no response is sent.

## Timing
- First accepted byte to state change: 1 cycle.
- Last frame byte accepted at edge N: wb_stb_o is high from N+1.
- wb_ack_i sampled high at edge M: wb_stb_o is low and tx_valid_o is high after M. Zero-wait-state slave, such as UART_C with a combinational ack: stb is high for exactly 1 cycle.
- Timeout: wb_stb_o is high for exactly BUS_TIMEOUT cycles.
- If tx_ready_i is already high on RESP entry, the response transfers in 1 cycle and IDLE is re-entered the next cycle. A new command can start on the following edge.
- wb_ack_i outside BUS is ignored.

## Structure
- Shared package (cpuconfig include): opcode constants CMD_WR=0x57, CMD_RD=0x52, RSP_OK=0x4B, RSP_TO=0xEE, and the state encoding localparams.
- Single module with no sub-modules. The UART is instantiated beside it at top level, and the bus is muxed with the CPU master by a separate arbiter.

## Test plan
- Write: send 57 01 A5 with an ack after 2 cycles -> one stb pulse of 3 cycles with adr=01, we=1, dat_o=A5; response 4B.
- Read: send 52 00, slave returns 3C with a zero-wait ack -> 1-cycle stb with we=0; response 3C.
- Timeout: BUS_TIMEOUT=4, send 52 10, never ack -> stb high for exactly 4 cycles; response EE; the next command works normally.
- Resync: send 52, wait BYTE_TIMEOUT cycles, then send 52 20 -> no bus activity until the second frame; one read of 0x20.
- Garbage: send FF 00 41 followed by 57 02 11 -> garbage discarded; a single write to 02; response 4B.
- Back-pressure and reset: hold tx_ready_i=0 for 10 cycles -> tx_valid_o and tx_dat_o stable and rx_ready_o=0. Separately, assert wb_rst_i during BUS -> stb=0 next edge; no response.
